// File: rtl/combo_pkg.sv
// combo_pkg: shared constants and the reference evaluation of the g/h cell.
package combo_pkg;

    // Default width of each activity counter.
    localparam int unsigned CNT_W_DEFAULT = 16;

    // Evaluate the cell; returns {g, h}. nor_bc is the term shared by both outputs.
    function automatic logic [1:0] combo_eval(
        input logic a,
        input logic b,
        input logic c,
        input logic d
    );
        logic nor_bc;
        logic g;
        logic h;
        nor_bc = ~(b | c);
        g      = (a & b) | nor_bc;
        h      = ~(nor_bc & d);
        return {g, h};
    endfunction

endpackage

// File: rtl/combo_core.sv
// combo_core: purely combinational g/h evaluation, no clock or reset.
module combo_core
    import combo_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic g,
    output logic h
);

    logic [1:0] gh_s;

    // Evaluate both outputs through the shared package function.
    always_comb begin
        gh_s = combo_eval(a, b, c, d);
    end

    assign g = gh_s[1];
    assign h = gh_s[0];

endmodule

// File: rtl/combo_logic.sv
// combo_logic: g/h cell with a one-cycle registered copy and saturating
// activity counters (cycles with g high, cycles with h low).
module combo_logic
    import combo_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             cnt_clr,
    output logic             g,
    output logic             h,
    output logic             g_q,
    output logic             h_q,
    output logic             q_valid,
    output logic [CNT_W-1:0] g_cnt,
    output logic [CNT_W-1:0] h_low_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             g_s;
    logic             h_s;
    logic             g_q_r;
    logic             h_q_r;
    logic             q_valid_r;
    logic [CNT_W-1:0] g_cnt_r;
    logic [CNT_W-1:0] h_low_cnt_r;
    logic [CNT_W-1:0] g_cnt_nxt_s;
    logic [CNT_W-1:0] h_low_cnt_nxt_s;

    combo_core u_core (
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .g (g_s),
        .h (h_s)
    );

    assign g = g_s;
    assign h = h_s;

    // Next value of the g-high counter: clear wins, otherwise saturating increment.
    always_comb begin
        g_cnt_nxt_s = g_cnt_r;
        if (cnt_clr) begin
            g_cnt_nxt_s = CNT_ZERO;
        end else if (g_s && (g_cnt_r != CNT_MAX)) begin
            g_cnt_nxt_s = g_cnt_r + CNT_ONE;
        end else begin
            g_cnt_nxt_s = g_cnt_r;
        end
    end

    // Next value of the h-low counter: clear wins, otherwise saturating increment.
    always_comb begin
        h_low_cnt_nxt_s = h_low_cnt_r;
        if (cnt_clr) begin
            h_low_cnt_nxt_s = CNT_ZERO;
        end else if (!h_s && (h_low_cnt_r != CNT_MAX)) begin
            h_low_cnt_nxt_s = h_low_cnt_r + CNT_ONE;
        end else begin
            h_low_cnt_nxt_s = h_low_cnt_r;
        end
    end

    // Output registers and counters with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_q_r       <= 1'b0;
            h_q_r       <= 1'b0;
            q_valid_r   <= 1'b0;
            g_cnt_r     <= CNT_ZERO;
            h_low_cnt_r <= CNT_ZERO;
        end else begin
            g_q_r       <= g_s;
            h_q_r       <= h_s;
            q_valid_r   <= 1'b1;
            g_cnt_r     <= g_cnt_nxt_s;
            h_low_cnt_r <= h_low_cnt_nxt_s;
        end
    end

    assign g_q       = g_q_r;
    assign h_q       = h_q_r;
    assign q_valid   = q_valid_r;
    assign g_cnt     = g_cnt_r;
    assign h_low_cnt = h_low_cnt_r;

endmodule

// File: tb/tb_combo_logic.sv
// tb_combo_logic: random and directed checks of combo_logic against a
// truth-table / counting model held in the bench.
module tb_combo_logic;

    localparam int unsigned TB_CNT_W = 2;
    localparam int          CNT_SAT  = 3;

    logic                clk;
    logic                rst_n;
    logic                a;
    logic                b;
    logic                c;
    logic                d;
    logic                cnt_clr;
    logic                g;
    logic                h;
    logic                g_q;
    logic                h_q;
    logic                q_valid;
    logic [TB_CNT_W-1:0] g_cnt;
    logic [TB_CNT_W-1:0] h_low_cnt;

    int n_chk;
    int n_err;

    // Reference model state
    int m_gq;
    int m_hq;
    int m_valid;
    int m_gcnt;
    int m_hcnt;

    combo_logic #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .cnt_clr   (cnt_clr),
        .g         (g),
        .h         (h),
        .g_q       (g_q),
        .h_q       (h_q),
        .q_valid   (q_valid),
        .g_cnt     (g_cnt),
        .h_low_cnt (h_low_cnt)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Truth-table view of g: high when a and b both 1, or b and c both 0
    function automatic int ref_g(input int ia, input int ib, input int ic);
        return ((ia == 1 && ib == 1) || (ib == 0 && ic == 0)) ? 1 : 0;
    endfunction

    // Truth-table view of h: low only for b=0, c=0, d=1
    function automatic int ref_h(input int ib, input int ic, input int id);
        return (ib == 0 && ic == 0 && id == 1) ? 0 : 1;
    endfunction

    task automatic check_comb(input string tag);
        chk({tag, ".g"}, 32'(g), 32'(ref_g(int'(a), int'(b), int'(c))));
        chk({tag, ".h"}, 32'(h), 32'(ref_h(int'(b), int'(c), int'(d))));
    endtask

    // Advance one clock with the currently driven inputs, update model, check registers
    task automatic step(input string tag);
        int gv;
        int hv;
        @(posedge clk);
        gv = ref_g(int'(a), int'(b), int'(c));
        hv = ref_h(int'(b), int'(c), int'(d));
        if (rst_n !== 1'b1) begin
            m_gq = 0; m_hq = 0; m_valid = 0; m_gcnt = 0; m_hcnt = 0;
        end else begin
            m_gq = gv;
            m_hq = hv;
            m_valid = 1;
            if (cnt_clr === 1'b1) begin
                m_gcnt = 0;
                m_hcnt = 0;
            end else begin
                if (gv == 1 && m_gcnt < CNT_SAT) m_gcnt++;
                if (hv == 0 && m_hcnt < CNT_SAT) m_hcnt++;
            end
        end
        @(negedge clk);
        chk({tag, ".g_q"},       32'(g_q),       32'(m_gq));
        chk({tag, ".h_q"},       32'(h_q),       32'(m_hq));
        chk({tag, ".q_valid"},   32'(q_valid),   32'(m_valid));
        chk({tag, ".g_cnt"},     32'(g_cnt),     32'(m_gcnt));
        chk({tag, ".h_low_cnt"}, 32'(h_low_cnt), 32'(m_hcnt));
    endtask

    logic [5:0] vec_tbl [5];

    initial begin
        n_chk = 0;
        n_err = 0;
        m_gq = 0; m_hq = 0; m_valid = 0; m_gcnt = 0; m_hcnt = 0;
        rst_n   = 1'b0;
        cnt_clr = 1'b0;
        {a, b, c, d} = 4'b0000;

        // Reset held two cycles with inputs toggling; comb outputs keep tracking
        for (int i = 0; i < 2; i++) begin
            {a, b, c, d} = 4'($urandom_range(0, 15));
            cnt_clr = 1'($urandom_range(0, 1));
            #1;
            check_comb("rst_comb");
            step("reset");
        end
        chk("rst.g_q_const",   32'(g_q),     32'd0);
        chk("rst.valid_const", 32'(q_valid), 32'd0);

        // Exhaustive combinational sweep
        for (int v = 0; v < 16; v++) begin
            {a, b, c, d} = 4'(v);
            #1;
            check_comb("exh");
        end

        // Directed vectors: {a,b,c,d,g,h}
        vec_tbl[0] = 6'b0000_11;
        vec_tbl[1] = 6'b0001_10;
        vec_tbl[2] = 6'b0101_01;
        vec_tbl[3] = 6'b1111_11;
        vec_tbl[4] = 6'b0011_01;
        for (int i = 0; i < 5; i++) begin
            {a, b, c, d} = vec_tbl[i][5:2];
            #1;
            chk("vec.g", 32'(g), 32'(vec_tbl[i][1]));
            chk("vec.h", 32'(h), 32'(vec_tbl[i][0]));
        end

        // Random combinational iterations: zero all inputs, then randomize
        for (int i = 0; i < 20; i++) begin
            {a, b, c, d} = 4'b0000;
            #1;
            {a, b, c, d} = 4'($urandom_range(0, 15));
            #1;
            check_comb("rnd");
        end
        if (n_err != 0) begin
            $display("FAIL rnd: combinational outputs disagree with reference equations");
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $fatal(1, "combinational mismatch");
        end

        // Realign to the falling edge and release reset
        @(negedge clk);
        rst_n   = 1'b1;
        cnt_clr = 1'b1;
        step("clr0");
        cnt_clr = 1'b0;

        // Pipeline: b=0, c=0, d=1 gives g=1, h=0 one cycle later
        a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b1;
        step("pipe");
        chk("pipe.h_q_const", 32'(h_q),     32'd0);
        chk("pipe.g_q_const", 32'(g_q),     32'd1);
        chk("pipe.valid",     32'(q_valid), 32'd1);

        // Randomized clocked traffic with occasional clears
        for (int i = 0; i < 30; i++) begin
            {a, b, c, d} = 4'($urandom_range(0, 15));
            cnt_clr = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            #1;
            check_comb("run_comb");
            step("run");
        end

        // Saturation: clear, then hold b=c=0, d=1 for five cycles
        cnt_clr = 1'b1;
        step("sat_clr");
        cnt_clr = 1'b0;
        a = 1'b1; b = 1'b0; c = 1'b0; d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("sat");
        end
        chk("sat.g_cnt_const", 32'(g_cnt),     32'd3);
        chk("sat.h_cnt_const", 32'(h_low_cnt), 32'd3);

        // Clear beats increment while the inputs still request counting
        cnt_clr = 1'b1;
        step("clr_pri");
        chk("clr_pri.g_cnt_const", 32'(g_cnt),     32'd0);
        chk("clr_pri.h_cnt_const", 32'(h_low_cnt), 32'd0);
        cnt_clr = 1'b0;
        step("recount");

        // Mid-operation reset clears everything
        rst_n = 1'b0;
        step("mid_rst");
        chk("mid_rst.valid_const", 32'(q_valid), 32'd0);
        chk("mid_rst.g_cnt_const", 32'(g_cnt),   32'd0);
        rst_n = 1'b1;
        step("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/combo_logic.md
# combo_logic

Two-output combinational logic cell computing g and h from inputs a, b, c, d. It also provides a registered copy of both outputs and saturating activity counters for system-level observation. Consumers may use the zero-latency combinational outputs or the one-cycle registered outputs. It sits as a small leaf block in control-decode paths.

## Interface
Parameters:
- CNT_W, default 16: width of each activity counter, minimum 2.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all sequential logic is on its rising edge.
- rst_n  in  1  reset; one clock, synchronous and active-low.
- a  in  1  data input.
- b  in  1  data input.
- c  in  1  data input.
- d  in  1  data input.
- cnt_clr  in  1  synchronous clear of both counters.
- g  out  1  combinational output, g = (a & b) | ~(b | c).
- h  out  1  combinational output, h = ~(~(b | c) & d), which equals b | c | ~d.
- g_q  out  1  g registered one cycle.
- h_q  out  1  h registered one cycle.
- q_valid  out  1  high once g_q and h_q hold post-reset data.
- g_cnt  out  CNT_W  count of cycles with g = 1, saturating.
- h_low_cnt  out  CNT_W  count of cycles with h = 0, saturating.

## Operation
- Define nor_bc = ~(b | c). It is shared by both outputs.
- g and h are purely combinational. They do not depend on clk, rst_n or cnt_clr, including while reset is active.
- Truth of g: g = 1 when (a = 1 and b = 1) or (b = 0 and c = 0). Otherwise g = 0.
- Truth of h: h = 0 only when b = 0, c = 0 and d = 1. Otherwise h = 1.
- Registered path: every rising clk edge with rst_n = 1 loads g_q <= g, h_q <= h and q_valid <= 1.
- Counters, updated on each rising edge with rst_n = 1:
  - If cnt_clr = 1, both counters become 0. Clear has priority over increment.
  - Otherwise g_cnt increments when g = 1, and h_low_cnt increments when h = 0.
  - Each counter holds at 2^CNT_W - 1 once it reaches that value. It never wraps.
- X on any input may propagate to the outputs. There is no X filtering.

## Timing
- g and h: zero-cycle latency. They must settle well within 1 time unit of an input change. No glitch-free guarantee.
- g_q, h_q: one-cycle latency; they reflect the inputs sampled at the previous rising edge.
- Reset values, taking effect at the first rising edge with rst_n = 0: g_q = 0, h_q = 0, q_valid = 0, g_cnt = 0, h_low_cnt = 0.
- The first edge after rst_n rises loads real data and sets q_valid = 1.
- Reset asserted mid-operation clears all registers at the next edge, regardless of cnt_clr or the inputs.
- When cnt_clr and an increment condition occur together, the counter result is 0.

## Structure
- Package combo_pkg holds:
  - the CNT_W default constant;
  - function automatic combo_eval(a, b, c, d), returning {g, h}, for reuse by RTL and models.
- Natural sub-module combo_core: purely combinational, with ports a, b, c, d, g, h and no clock. combo_logic instantiates it and adds the registers and counters.

## Test plan
- Exhaustive 16 input combinations, checked about 1 time unit after each apply:
  - a=0, b=0, c=0, d=0 -> g=1, h=1.
  - a=0, b=0, c=0, d=1 -> g=1, h=0.
  - a=0, b=1, c=0, d=1 -> g=0, h=1.
  - a=1, b=1, c=1, d=1 -> g=1, h=1.
  - a=0, b=0, c=1, d=1 -> g=0, h=1.
- Random: 20 iterations, each driving all inputs to 0, then random a, b, c, d. After 1 time unit, g and h must match the reference equations. Any mismatch is fatal.
- Reset: hold rst_n=0 for 2 cycles with inputs toggling.
  - Required: g_q = h_q = q_valid = 0 and both counters = 0.
  - Required: g and h keep tracking the inputs combinationally.
- Pipeline: apply b=0, c=0, d=1 before an edge. Required after that edge: h_q = 0, g_q = 1, q_valid = 1.
- Counters: with CNT_W=2, hold b=c=0, d=1 for 5 cycles.
  - Required: g_cnt = 3 and h_low_cnt = 3 (saturated).
  - Then pulse cnt_clr while still holding these inputs. Required: both counters = 0 on the next edge.
